// File: rtl/lut_mult_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier between two requesters.
// Optional grant statistics counters are enabled by defining LUT_MULT_ARB_STATS_EN.
module lut_mult_arbiter #(
    parameter int DATA_W      = 8,
    parameter int MUL_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [DATA_W-1:0]     req0_a,
    input  logic [DATA_W-1:0]     req0_b,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_W-1:0]     req1_a,
    input  logic [DATA_W-1:0]     req1_b,
    output logic                  req1_ready,
    output logic [DATA_W-1:0]     mul_a,
    output logic [DATA_W-1:0]     mul_b,
    input  logic [2*DATA_W-1:0]   mul_product,
    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    output logic [2*DATA_W-1:0]   rsp_product,
    output logic                  busy
`ifdef LUT_MULT_ARB_STATS_EN
    ,
    output logic [15:0]           grant_cnt0,
    output logic [15:0]           grant_cnt1
`endif
);

    // Handshake: a requester's operands transfer on a rising edge where its
    // valid and ready are both 1; requesters hold valid/a/b stable until ready.
    localparam logic [0:0] PTR_REQ0 = 1'b0;
    localparam logic [0:0] PTR_REQ1 = 1'b1;

    logic [0:0]            ptr_q, ptr_d;
    logic [DATA_W-1:0]     mul_a_q, mul_a_d;
    logic [DATA_W-1:0]     mul_b_q, mul_b_d;
    logic [MUL_LATENCY:0]  tag_vld_q, tag_vld_d;
    logic [MUL_LATENCY:0]  tag_id_q, tag_id_d;
    logic [2*DATA_W-1:0]   rsp_product_q, rsp_product_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic                  busy_q, busy_d;
    logic                  grant0, grant1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && (!req1_valid || ptr_q == PTR_REQ0)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (grant0) begin
            ptr_d   = PTR_REQ1;
            mul_a_d = req0_a;
            mul_b_d = req0_b;
        end else if (grant1) begin
            ptr_d   = PTR_REQ0;
            mul_a_d = req1_a;
            mul_b_d = req1_b;
        end
    end

    // The tag pipe never stalls; its last stage lines up with mul_product.
    always_comb begin
        tag_vld_d     = {tag_vld_q[MUL_LATENCY-1:0], grant0 | grant1};
        tag_id_d      = {tag_id_q[MUL_LATENCY-1:0], grant1};
        rsp0_valid_d  = tag_vld_q[MUL_LATENCY] && !tag_id_q[MUL_LATENCY];
        rsp1_valid_d  = tag_vld_q[MUL_LATENCY] &&  tag_id_q[MUL_LATENCY];
        rsp_product_d = tag_vld_q[MUL_LATENCY] ? mul_product : rsp_product_q;
        busy_d        = (|tag_vld_d) | rsp0_valid_d | rsp1_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= PTR_REQ0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            tag_vld_q     <= '0;
            tag_id_q      <= '0;
            rsp_product_q <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            tag_vld_q     <= tag_vld_d;
            tag_id_q      <= tag_id_d;
            rsp_product_q <= rsp_product_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign rsp_product = rsp_product_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign busy        = busy_q;

`ifdef LUT_MULT_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (grant0 && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
        if (grant1 && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_lut_mult_arbiter.sv
// Self-checking bench for lut_mult_arbiter: directed test-plan steps followed by
// randomized traffic, checked against a transaction-level model with a due-cycle queue.
module tb_lut_mult_arbiter;

    localparam int W  = 8;
    localparam int ML = 2;

    logic            clk;
    logic            rst;
    logic            req0_valid, req1_valid;
    logic [W-1:0]    req0_a, req0_b, req1_a, req1_b;
    logic            req0_ready, req1_ready;
    logic [W-1:0]    mul_a, mul_b;
    logic [2*W-1:0]  mul_product;
    logic            rsp0_valid, rsp1_valid;
    logic [2*W-1:0]  rsp_product;
    logic            busy;
`ifdef LUT_MULT_ARB_STATS_EN
    logic [15:0]     grant_cnt0, grant_cnt1;
`endif

    lut_mult_arbiter #(.DATA_W(W), .MUL_LATENCY(ML)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_product(rsp_product),
        .busy(busy)
`ifdef LUT_MULT_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external multiplier: ML edges from operands to product.
    logic [2*W-1:0] mpipe [ML];
    always @(posedge clk) begin
        mpipe[0] <= smul(mul_a, mul_b);
        for (int i = 1; i < ML; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_product = mpipe[ML-1];

    function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    // Reference model: pointer, expected register values, response queue.
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    logic           m_ptr;
    logic [W-1:0]   m_mul_a, m_mul_b;
    logic [2*W-1:0] m_rsp;
    int             exp_due[$];
    logic           exp_id[$];
    logic [2*W-1:0] exp_q[$];
    int             m_cnt0, m_cnt1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
    endtask

    // One clock: check grants before the edge, model the edge, check outputs after.
    task automatic step(output logic g0, output logic g1);
        logic in_rst;
        logic e0, e1;
        #3;
        in_rst = rst;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!in_rst) begin
            if (req0_valid && req1_valid) begin
                g0 = (m_ptr == 1'b0);
                g1 = (m_ptr == 1'b1);
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
        end
        check("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
        if (in_rst) begin
            m_ptr = 1'b0; m_mul_a = '0; m_mul_b = '0; m_rsp = '0;
            exp_due.delete(); exp_id.delete(); exp_q.delete();
            m_cnt0 = 0; m_cnt1 = 0;
        end else if (g0 || g1) begin
            m_mul_a = g0 ? req0_a : req1_a;
            m_mul_b = g0 ? req0_b : req1_b;
            exp_due.push_back(cyc + 1 + ML + 1);
            exp_id.push_back(g1);
            exp_q.push_back(smul(m_mul_a, m_mul_b));
            m_ptr = g0;
            if (g0 && m_cnt0 < 65535) m_cnt0++;
            if (g1 && m_cnt1 < 65535) m_cnt1++;
        end
        @(posedge clk);
        cyc++;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (exp_due.size() > 0 && exp_due[0] == cyc) begin
            e0 = !exp_id[0];
            e1 =  exp_id[0];
            m_rsp = exp_q[0];
        end
        check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, e0});
        check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, e1});
        check("rsp_product", {16'd0, rsp_product}, {16'd0, m_rsp});
        check("busy", {31'd0, busy}, {31'd0, exp_due.size() > 0});
        check("mul_a", {24'd0, mul_a}, {24'd0, m_mul_a});
        check("mul_b", {24'd0, mul_b}, {24'd0, m_mul_b});
`ifdef LUT_MULT_ARB_STATS_EN
        check("grant_cnt0", {16'd0, grant_cnt0}, m_cnt0);
        check("grant_cnt1", {16'd0, grant_cnt1}, m_cnt1);
`endif
        if (e0 || e1) begin
            void'(exp_due.pop_front());
            void'(exp_id.pop_front());
            void'(exp_q.pop_front());
        end
    endtask

    task automatic idle(input int n);
        logic g0, g1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) step(g0, g1);
    endtask

    initial begin
        logic         g0, g1;
        logic         p0, p1;
        logic [W-1:0] ra0, rb0, ra1, rb1;
        m_ptr = 1'b0; m_mul_a = '0; m_mul_b = '0; m_rsp = '0;
        m_cnt0 = 0; m_cnt1 = 0;
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        @(posedge clk);
        #1;

        // Reset held for three cycles, then idle
        for (int i = 0; i < 3; i++) step(g0, g1);
        rst = 1'b0;
        idle(2);

        // Single request on requester 0: 5*4
        drive(1'b1, 8'd5, 8'd4, 1'b0, '0, '0);
        step(g0, g1);
        idle(4);
        check("single_product", {16'd0, rsp_product}, 32'd20);

        // Signed request on requester 1: -9*7
        drive(1'b0, '0, '0, 1'b1, 8'hF7, 8'd7);
        step(g0, g1);
        idle(4);
        check("signed_product", {16'd0, rsp_product}, 32'h0000FFC1);

        // Contention: both valid for four cycles, expect 0,1,0,1
        drive(1'b1, 8'd5, 8'd4, 1'b1, 8'hF7, 8'd7);
        for (int i = 0; i < 4; i++) begin
            step(g0, g1);
            check("contention_grant1", {31'd0, g1}, {31'd0, (i % 2) == 1});
        end
        idle(5);

        // Reset one cycle after an accept drops the operation
        drive(1'b1, 8'd3, 8'd3, 1'b0, '0, '0);
        step(g0, g1);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        rst = 1'b1;
        step(g0, g1);
        rst = 1'b0;
        idle(5);
        drive(1'b1, 8'd2, 8'd6, 1'b1, 8'd1, 8'd1);
        step(g0, g1);
        check("ptr_after_reset", {31'd0, g0}, 32'd1);
        idle(5);

        // Randomized traffic with hold-until-ready, occasional drops and resets
        p0 = 1'b0; p1 = 1'b0;
        ra0 = '0; rb0 = '0; ra1 = '0; rb1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1'b1; ra0 = W'($urandom); rb0 = W'($urandom);
            end else if (p0 && $urandom_range(0, 15) == 0) begin
                p0 = 1'b0;
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1'b1; ra1 = W'($urandom); rb1 = W'($urandom);
            end else if (p1 && $urandom_range(0, 15) == 0) begin
                p1 = 1'b0;
            end
            rst = ($urandom_range(0, 99) == 0);
            drive(p0, ra0, rb0, p1, ra1, rb1);
            step(g0, g1);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
        end
        rst = 1'b0;
        idle(6);

`ifdef LUT_MULT_ARB_STATS_EN
        // Counter values after a clean reset, then saturation on a long run
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(1'b1, 8'd1, 8'd2, 1'b0, '0, '0);
            else       drive(1'b0, '0, '0, 1'b1, 8'd3, 8'd4);
            step(g0, g1);
        end
        idle(4);
        check("stats_cnt0", {16'd0, grant_cnt0}, 32'd5);
        check("stats_cnt1", {16'd0, grant_cnt1}, 32'd2);
        drive(1'b1, 8'd1, 8'd1, 1'b0, '0, '0);
        for (int i = 0; i < 65540; i++) step(g0, g1);
        idle(4);
        check("stats_saturate", {16'd0, grant_cnt0}, 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
